// File: rtl/iram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller and its output queue.
package iram_fifo_ctrl_pkg;

  localparam int OUTQ_DEPTH = 2;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  // Holds 0..DEPTH+2 words.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 3);
  endfunction

endpackage

// File: rtl/iram_fifo_outq.sv
// Two-entry output queue: head at slot 0, same-cycle pop and write both honoured.
module iram_fifo_outq
  import iram_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [1:0]       cnt,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [OUTQ_DEPTH];
  logic [1:0]       tail;
  logic             pop_ok;
  logic             wr_ok;

  assign pop_ok = pop & (cnt != 2'd0);
  assign tail   = cnt - {1'b0, pop_ok};
  assign wr_ok  = wr & (int'(tail) < OUTQ_DEPTH);
  assign head   = mem[0];

  // A write landing in slot 0 during a pop overrides the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < OUTQ_DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= tail + {1'b0, wr_ok};
      if (pop_ok) mem[0] <= mem[1];
      if (wr_ok) mem[tail[0]] <= wr_dat;
    end
  end

endmodule

// File: rtl/iram_fifo_ctrl.sv
// FIFO controller over a 1-cycle-latency RAM with 2-word prefetch; push-to-rd_vld is 3 cycles.
// Define IRAM_FIFO_BYPASS_EN to route pushes into an empty FIFO straight to the output queue (1 cycle).
module iram_fifo_ctrl
  import iram_fifo_ctrl_pkg::*;
#(
  parameter int ADDRBIT = 9,
  parameter int DEPTH   = 512,
  parameter int WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               wr_vld,
  output logic               wr_rdy,
  input  logic [WIDTH-1:0]   wr_dat,
  output logic               rd_vld,
  input  logic               rd_rdy,
  output logic [WIDTH-1:0]   rd_dat,
  output logic [ADDRBIT+1:0] count,
  output logic [ADDRBIT-1:0] ram_wa,
  output logic               ram_we,
  output logic [WIDTH-1:0]   ram_di,
  output logic [ADDRBIT-1:0] ram_ra,
  output logic               ram_re,
  input  logic [WIDTH-1:0]   ram_do,
  output logic               ram_test,
  output logic               ram_mask
);

  localparam int CW = cnt_width(DEPTH);

  logic [ADDRBIT-1:0] wptr, rptr;
  logic [ADDRBIT:0]   ram_cnt;
  logic               inflight;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         outq_cnt;
  logic [2:0]         occ;
  logic               push, pop, byp, push_ram, outq_wr;
  logic [WIDTH-1:0]   outq_dat;

  // Gating on rst_n keeps ram_we low while reset is held.
  assign wr_rdy   = rst_n & ~flush & (ram_cnt != (ADDRBIT+1)'(DEPTH));
  assign push     = wr_vld & wr_rdy;
  assign pop      = rd_vld & rd_rdy;
  assign occ      = {1'b0, outq_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign ram_re   = ~flush & (ram_cnt != '0) & (occ < 3'd2);

`ifdef IRAM_FIFO_BYPASS_EN
  assign byp = push & (ram_cnt == '0) & ~inflight & ((outq_cnt - {1'b0, pop}) < 2'd2);
`else
  assign byp = 1'b0;
`endif

  assign push_ram = push & ~byp;
  assign ram_we   = push_ram;
  assign ram_wa   = wptr;
  assign ram_di   = wr_dat;
  assign ram_ra   = rptr;
  assign ram_test = 1'b0;
  assign ram_mask = 1'b0;

  // Returning RAM word is dropped if a flush coincides with its arrival.
  assign outq_wr  = byp | (inflight & ~flush);
  assign outq_dat = byp ? wr_dat : ram_do;
  assign rd_vld   = (outq_cnt != 2'd0);
  assign count    = (ADDRBIT+2)'(cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      cnt_q    <= '0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_ram) wptr <= ADDRBIT'(ptr_inc(32'(wptr), DEPTH));
      if (ram_re)   rptr <= ADDRBIT'(ptr_inc(32'(rptr), DEPTH));
      ram_cnt  <= ram_cnt + (ADDRBIT+1)'(push_ram) - (ADDRBIT+1)'(ram_re);
      inflight <= ram_re;
      cnt_q    <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  iram_fifo_outq #(.WIDTH(WIDTH)) u_outq (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (flush),
    .wr     (outq_wr),
    .wr_dat (outq_dat),
    .pop    (pop),
    .cnt    (outq_cnt),
    .head   (rd_dat)
  );

endmodule

// File: tb/tb_iram_fifo_ctrl.sv
// Randomized scoreboard bench: a 512-deep instance for the main flows and a 5-deep one for pointer wrap.
module tb_iram_fifo_ctrl;

  localparam int AB = 9, D = 512, W = 32, AB5 = 3, D5 = 5;
`ifdef IRAM_FIFO_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          flush, wr_vld, wr_rdy, rd_vld, rd_rdy, ram_we, ram_re, ram_test, ram_mask;
  logic [W-1:0]  wr_dat, rd_dat, ram_di, ram_do;
  logic [AB+1:0] count;
  logic [AB-1:0] ram_wa, ram_ra;

  logic           flush5, wr_vld5, wr_rdy5, rd_vld5, rd_rdy5, ram_we5, ram_re5, ram_test5, ram_mask5;
  logic [W-1:0]   wr_dat5, rd_dat5, ram_di5, ram_do5;
  logic [AB5+1:0] count5;
  logic [AB5-1:0] ram_wa5, ram_ra5;

  iram_fifo_ctrl #(.ADDRBIT(AB), .DEPTH(D), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_dat(wr_dat),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_dat(rd_dat), .count(count),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_do(ram_do),
    .ram_test(ram_test), .ram_mask(ram_mask)
  );

  iram_fifo_ctrl #(.ADDRBIT(AB5), .DEPTH(D5), .WIDTH(W)) dut5 (
    .clk(clk), .rst_n(rst_n), .flush(flush5),
    .wr_vld(wr_vld5), .wr_rdy(wr_rdy5), .wr_dat(wr_dat5),
    .rd_vld(rd_vld5), .rd_rdy(rd_rdy5), .rd_dat(rd_dat5), .count(count5),
    .ram_wa(ram_wa5), .ram_we(ram_we5), .ram_di(ram_di5),
    .ram_ra(ram_ra5), .ram_re(ram_re5), .ram_do(ram_do5),
    .ram_test(ram_test5), .ram_mask(ram_mask5)
  );

  // Behavioural RAMs with one cycle of read latency.
  logic [W-1:0] mem  [D];
  logic [W-1:0] mem5 [8];
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa]   <= ram_di;
    if (ram_re)  ram_do        <= mem[ram_ra];
    if (ram_we5) mem5[ram_wa5] <= ram_di5;
    if (ram_re5) ram_do5       <= mem5[ram_ra5];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp5[$];
  int run = 0, last_pop = -10, popped5 = 0, exp_wa5 = 0, exp_ra5 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected words whenever a pop handshake is presented.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("collision", 64'(ram_we && ram_re && (ram_wa == ram_ra)), 0);
        chk("collision5", 64'(ram_we5 && ram_re5 && (ram_wa5 == ram_ra5)), 0);
        if (rd_vld && rd_rdy) begin
          if (exp_q.size() == 0) chk("pop_underflow", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("pop_data", 64'(rd_dat), 64'(e));
          end
          run = (last_pop == cyc - 1) ? run + 1 : 1;
          last_pop = cyc;
        end
        if (ram_we5) begin
          chk("wrap_wa", 64'(ram_wa5), 64'(exp_wa5));
          exp_wa5 = (exp_wa5 + 1) % D5;
        end
        if (ram_re5) begin
          chk("wrap_ra", 64'(ram_ra5), 64'(exp_ra5));
          exp_ra5 = (exp_ra5 + 1) % D5;
        end
        if (rd_vld5 && rd_rdy5) begin
          if (exp5.size() == 0) chk("pop5_underflow", 1, 0);
          else begin
            e = exp5.pop_front();
            chk("pop5_data", 64'(rd_dat5), 64'(e));
          end
          popped5++;
        end
      end
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic r, output logic acc);
    @(negedge clk);
    flush = 1'b0; wr_vld = v; wr_dat = d; rd_rdy = r;
    #1;
    acc = wr_vld && wr_rdy;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic drain(input string name);
    int k;
    logic a;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      step(1'b0, '0, 1'b1, a);
      k++;
    end
    chk({name, "_drain_timeout"}, 64'(k >= 2000), 0);
    step(1'b0, '0, 1'b0, a);
    chk({name, "_empty_vld"}, 64'(rd_vld), 0);
    chk({name, "_empty_count"}, 64'(count), 0);
  endtask

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic a;
    int lat, nxt, refuse_at, n, pushed5;
    flush = 0; wr_vld = 0; wr_dat = '0; rd_rdy = 0;
    flush5 = 0; wr_vld5 = 0; wr_dat5 = '0; rd_rdy5 = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_vld", 64'(rd_vld), 0);
    chk("rst_rd_dat", 64'(rd_dat), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_ram_we", 64'(ram_we), 0);
    chk("rst_ram_re", 64'(ram_re), 0);
    chk("rst_count5", 64'(count5), 0);
    @(negedge clk);
    rst_n = 1;

    // First-word latency.
    step(1'b1, 32'h11, 1'b0, a);
    lat = 0;
    do begin
      step(1'b0, '0, 1'b0, a);
      lat++;
    end while (!rd_vld && lat < 10);
    chk("latency", 64'(lat), 64'(EXP_LAT));
    chk("lat_rd_dat", 64'(rd_dat), 64'h11);
    chk("lat_count", 64'(count), 1);
    drain("lat");

    // Fill to DEPTH+2 with no pops, then drain in order.
    nxt = 0; refuse_at = -1;
    for (int i = 0; i < 520; i++) begin
      step(1'b1, W'(nxt), 1'b0, a);
      if (a) nxt++;
      else if (refuse_at < 0) refuse_at = i;
    end
    chk("full_accepts", 64'(nxt), D + 2);
    chk("full_refuse_at", 64'(refuse_at), D + 2);
    step(1'b0, '0, 1'b0, a);
    chk("full_wr_rdy", 64'(wr_rdy), 0);
    chk("full_count", 64'(count), D + 2);
    drain("full");

    // Streaming: one word in and one out every cycle.
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, W'($urandom), 1'b1, a);
      if (a) n++;
    end
    chk("stream_accepts", 64'(n), 1000);
    drain("stream");
    chk("stream_pop_run", 64'(run), 1000);

    // Random mix of push and pop pressure.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0), a);
    drain("mix");

    // Flush one cycle after a RAM read is issued, with a push attempt in the flush cycle.
    for (int i = 0; i < 7; i++) step(1'b1, W'($urandom), 1'b0, a);
    repeat (4) step(1'b0, '0, 1'b0, a);
    chk("flush_pre_count", 64'(count), 7);
    step(1'b0, '0, 1'b1, a);
    chk("flush_pre_re", 64'(ram_re), 1);
    @(negedge clk);
    flush = 1; wr_vld = 1; wr_dat = 32'hDEAD; rd_rdy = 0;
    #1;
    chk("flush_wr_rdy", 64'(wr_rdy), 0);
    exp_q.delete();
    step(1'b0, '0, 1'b0, a);
    chk("flush_count", 64'(count), 0);
    chk("flush_rd_vld", 64'(rd_vld), 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, a);
      chk("flush_drop", 64'(rd_vld), 0);
    end
    step(1'b1, 32'hA5, 1'b0, a);
    drain("flush_a5");

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 30; i++) step(1'b1, W'($urandom), 1'($urandom_range(0, 1)), a);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("arst_rd_vld", 64'(rd_vld), 0);
    chk("arst_rd_dat", 64'(rd_dat), 0);
    chk("arst_count", 64'(count), 0);
    chk("arst_ram_we", 64'(ram_we), 0);
    chk("arst_ram_re", 64'(ram_re), 0);
    exp_q.delete(); exp5.delete();
    exp_wa5 = 0; exp_ra5 = 0;
    @(negedge clk);
    wr_vld = 0; rd_rdy = 0; rst_n = 1;
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), a);
    drain("post_arst");

    // DEPTH=5 instance: fill past the RAM, then random pops across pointer wrap.
    pushed5 = 0; popped5 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      wr_vld5 = 1; wr_dat5 = W'($urandom); rd_rdy5 = 0;
      #1;
      if (wr_vld5 && wr_rdy5) begin exp5.push_back(wr_dat5); pushed5++; end
    end
    @(negedge clk);
    wr_vld5 = 0;
    #1;
    chk("wrap_full_accepts", 64'(pushed5), D5 + 2);
    chk("wrap_full_wr_rdy", 64'(wr_rdy5), 0);
    chk("wrap_full_count", 64'(count5), D5 + 2);
    for (int k = 0; k < 400 && popped5 < 20; k++) begin
      @(negedge clk);
      wr_vld5 = (pushed5 < 20) && ($urandom_range(0, 1) == 1);
      wr_dat5 = W'($urandom);
      rd_rdy5 = 1'($urandom_range(0, 1));
      #1;
      if (wr_vld5 && wr_rdy5) begin exp5.push_back(wr_dat5); pushed5++; end
    end
    @(negedge clk);
    wr_vld5 = 0; rd_rdy5 = 0;
    #1;
    chk("wrap_popped", 64'(popped5), 20);
    chk("wrap_count", 64'(count5), 0);
    chk("wrap_rd_vld", 64'(rd_vld5), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iram_fifo_ctrl.md
Name: iram_fifo_ctrl

Overview:
- Single-clock FIFO controller that owns a 1-cycle-latency read/write-port RAM instance (wa/we/di, ra/re/do, test/mask) and presents valid/ready push and pop interfaces.
- Prefetches RAM words into a 2-entry output queue so the pop side sustains 1 word/cycle.
- Never issues a same-address write and read in the same cycle, so the RAM's collision X-insertion and error report never fire.
- Sits between a producer datapath and its consumer wherever the team instantiates the RAM as a buffer.

Parameters:
ADDRBIT, 9, RAM address width
DEPTH, 512, RAM entries; 2 <= DEPTH <= 2**ADDRBIT, need not be a power of 2
WIDTH, 32, data width

Ports:
clk  in  1  single clock for controller and attached RAM (both RAM clocks tied here)
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of all contents
wr_vld  in  1  push request
wr_rdy  out  1  push accepted when wr_vld & wr_rdy
wr_dat  in  WIDTH  push data
rd_vld  out  1  head word valid
rd_rdy  in  1  pop when rd_vld & rd_rdy
rd_dat  out  WIDTH  head word
count  out  ADDRBIT+2  words held (RAM + in-flight + output queue), max DEPTH+2
ram_wa  out  ADDRBIT  RAM write address
ram_we  out  1  RAM write enable
ram_di  out  WIDTH  RAM write data
ram_ra  out  ADDRBIT  RAM read address
ram_re  out  1  RAM read enable
ram_do  in  WIDTH  RAM read data, valid the cycle after ram_re
ram_test  out  1  tied 0
ram_mask  out  1  tied 0

Behaviour:
- Reset (rst_n low, async): wptr=rptr=0, ram_cnt=0, inflight=0, outq empty, count=0, rd_vld=0, rd_dat=0. ram_we/ram_re are 0 during reset.
- Registered state:
  - wptr/rptr: ADDRBIT bits each; wrap DEPTH-1 -> 0.
  - ram_cnt: 0..DEPTH.
  - inflight: 1 bit.
  - outq: 2 entries, with outq_cnt.
- Push side:
  - wr_rdy = ~flush & (ram_cnt != DEPTH).
  - Accepted push: ram_we=1, ram_wa=wptr, ram_di=wr_dat; wptr advances.
- Read issue:
  - pop = rd_vld & rd_rdy.
  - ram_re = ~flush & (ram_cnt != 0) & (outq_cnt + inflight - pop < 2); ram_ra=rptr; rptr advances.
  - inflight for the next cycle = ram_re.
- Collision rule: a read is issued only when ram_cnt>0 and a write only when ram_cnt<DEPTH (registered values). Therefore ra==wa never occurs with we&re both high. The bench asserts this every cycle.
- Return path: in the cycle after ram_re, ram_do is written into the outq tail; ram_do is ignored at all other times.
- Counters:
  - ram_cnt_next = ram_cnt + push - ram_re.
  - count_next = count + push - pop.
- Output: rd_vld = (outq_cnt != 0); rd_dat = outq head. A pop and a capture in the same cycle are both honoured.
- Latency: push accepted in cycle t into an empty FIFO -> ram_re in t+1 -> capture at end of t+2 -> rd_vld=1 in t+3.
- Throughput: 1 push and 1 pop per cycle sustained when count>=3.
- Full: count=DEPTH+2 (RAM full, outq full) -> wr_rdy=0. Simultaneous pop and full does not raise wr_rdy until ram_cnt drops (registered).
- Empty: rd_vld=0; pop ignored.
- Flush:
  - Has priority over push, pop and issue in that cycle; pointers, counts, outq and inflight clear at the next edge.
  - A RAM word returning the cycle after flush is discarded.
  - rd_vld=0 the cycle after flush.
- Async reset mid-operation: same as flush, immediate. RAM contents are not cleared.

Optional Feature:
- Macro: IRAM_FIFO_BYPASS_EN.
- Defined:
  - When ram_cnt==0 & ~inflight & (outq_cnt - pop < 2), an accepted push bypasses the RAM (ram_we=0) and writes wr_dat directly into the outq tail.
  - Push-to-rd_vld latency becomes 1 cycle; ordering is preserved because nothing older exists.
- Undefined: every push goes through the RAM; latency is 3 cycles.

Decomposition:
- Shared package:
  - OUTQ_DEPTH=2 constant.
  - Pointer-increment-with-wrap function (ptr, DEPTH).
  - Count-width function clog2(DEPTH+3).
- One sub-module: iram_fifo_outq, the 2-entry output queue with wr/pop/cnt and head output. The pointer/issue logic stays in the top.

Test Plan:
- After reset, push 0x11 once, no pop -> rd_vld rises in cycle t+3 (t+1 with IRAM_FIFO_BYPASS_EN), rd_dat=0x11, count=1.
- Push 514 words 0..513 with rd_rdy=0 (DEPTH=512) -> wr_rdy=0 after the 514th accept, count=514. Then pop all -> values 0..513 in order; rd_vld=0 afterwards.
- Continuous push and pop with rd_rdy=1, 1000 words -> one word out per cycle in steady state, order preserved, and no cycle has ram_we & ram_re & ram_wa==ram_ra.
- Pointer wrap with DEPTH=5: push/pop 20 words with random rd_rdy -> addresses cycle 0..4, data order exact.
- Flush asserted the cycle after a ram_re, with count=7 -> next cycle count=0, rd_vld=0, returning data dropped. A subsequent push of 0xA5 is popped as 0xA5.
- rst_n pulsed low asynchronously mid-burst -> all outputs reach reset values without a clock edge. The FIFO then operates normally from empty.
